// File: rtl/rd_tran_sequencer_pkg.sv
// Shared encodings for the read transaction sequencer: FSM states, source op codes,
// AXI burst codes and the RRESP error bit.
package rd_tran_sequencer_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ADDR = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_POP  = 3'd3;
    localparam logic [2:0] ST_ERR  = 3'd4;

    localparam logic [1:0] OP_INCR  = 2'b00;
    localparam logic [1:0] OP_FIXED = 2'b01;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_FIXED = 2'b00;

    localparam int unsigned RRESP_ERR_BIT      = 1;
    localparam int unsigned MAX_BEAT_SIZE_LOG2 = 3;

    // Low address bits that must be zero for a beat of 2**size bytes.
    function automatic logic [11:0] beat_mask(input logic [2:0] size);
        return 12'((12'd1 << size) - 12'd1);
    endfunction

endpackage

// File: rtl/rd_burst_len_calc.sv
// Burst length = min(beats left, MAX_BURST_LEN, beats to next 4KB boundary).
// The 4KB term exists only when RD_TRAN_SEQ_4K_SPLIT_EN is defined, and only for INCR.
module rd_burst_len_calc #(
    parameter int unsigned BEATS_W       = 23,
    parameter int unsigned MAX_BURST_LEN = 16
) (
    input  logic [BEATS_W-1:0] beats_left_i,
    input  logic [11:0]        addr_lo_i,
    input  logic [2:0]         size_i,
    input  logic               incr_i,
    output logic [8:0]         len_o
);

`ifdef RD_TRAN_SEQ_4K_SPLIT_EN
    logic [12:0] dist;

    always_comb begin
        dist  = (13'h1000 - {1'b0, addr_lo_i}) >> size_i;
        len_o = 9'(MAX_BURST_LEN);
        if (32'(beats_left_i) < MAX_BURST_LEN) len_o = 9'(beats_left_i);
        if (incr_i && (dist < {4'b0000, len_o})) len_o = dist[8:0];
    end
`else
    logic unused_4k;
    assign unused_4k = ^{addr_lo_i, size_i, incr_i};

    always_comb begin
        len_o = 9'(MAX_BURST_LEN);
        if (32'(beats_left_i) < MAX_BURST_LEN) len_o = 9'(beats_left_i);
    end
`endif

endmodule

// File: rtl/rd_tran_sequencer.sv
// Pops entries from the two-slot read transaction queue, splits each into AXI4 AR bursts
// and counts R beats. Define RD_TRAN_SEQ_4K_SPLIT_EN to keep INCR bursts inside 4KB pages.
module rd_tran_sequencer
    import rd_tran_sequencer_pkg::*;
#(
    parameter int unsigned MAX_TRAN_SIZE_WIDTH = 23,
    parameter int unsigned MAX_BURST_LEN       = 16
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           reqInQueue,
    input  logic                           dataValid,
    input  logic [31:0]                    srcAddr,
    input  logic [1:0]                     srcOp,
    input  logic [2:0]                     srcDataWidth,
    input  logic [MAX_TRAN_SIZE_WIDTH-1:0] numOfBytes,
    input  logic                           spaceWrTranQueue,
    output logic                           rdCache1Sel,
    output logic [1:0]                     clrRdTranQueue,
    output logic                           arvalid,
    output logic [31:0]                    araddr,
    output logic [7:0]                     arlen,
    output logic [2:0]                     arsize,
    output logic [1:0]                     arburst,
    input  logic                           arready,
    input  logic                           rvalid,
    input  logic                           rlast,
    input  logic [1:0]                     rresp,
    output logic                           rready,
    output logic                           tranDone,
    output logic                           tranErr
);

    localparam int unsigned BW  = MAX_TRAN_SIZE_WIDTH;
    localparam int unsigned BW1 = MAX_TRAN_SIZE_WIDTH + 1;

    logic [2:0]    state_q, state_d;
    logic          sel_q, sel_d;
    logic [31:0]   addr_q, addr_d;
    logic [BW-1:0] beats_q, beats_d;
    logic [8:0]    burst_q, burst_d;
    logic [8:0]    len_q, len_d;
    logic [2:0]    size_q, size_d;
    logic [1:0]    op_q, op_d;
    logic          err_q, err_d;
    logic [8:0]    len_w;
    logic [BW:0]   bytes_rnd;
    logic          bad_desc;
    logic          beat_err;

    rd_burst_len_calc #(
        .BEATS_W       (BW),
        .MAX_BURST_LEN (MAX_BURST_LEN)
    ) u_len (
        .beats_left_i (beats_q),
        .addr_lo_i    (addr_q[11:0]),
        .size_i       (size_q),
        .incr_i       (op_q == OP_INCR),
        .len_o        (len_w)
    );

    // Round the byte count up to whole beats before shifting.
    assign bytes_rnd = {1'b0, numOfBytes} + BW1'(beat_mask(srcDataWidth));
    assign bad_desc  = (srcDataWidth > 3'(MAX_BEAT_SIZE_LOG2)) || srcOp[1] ||
                       (numOfBytes == '0) || (|(srcAddr[11:0] & beat_mask(srcDataWidth)));

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        addr_d   = addr_q;
        beats_d  = beats_q;
        burst_d  = burst_q;
        len_d    = len_q;
        size_d   = size_q;
        op_d     = op_q;
        err_d    = err_q;
        beat_err = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (reqInQueue && spaceWrTranQueue) begin
                    if (!dataValid) begin
                        state_d = ST_POP;
                    end else if (bad_desc) begin
                        state_d = ST_ERR;
                    end else begin
                        addr_d  = srcAddr;
                        beats_d = BW'(bytes_rnd >> srcDataWidth);
                        size_d  = srcDataWidth;
                        op_d    = srcOp;
                        err_d   = 1'b0;
                        state_d = ST_ADDR;
                    end
                end
            end
            ST_ADDR: begin
                if (arready) begin
                    burst_d = len_w;
                    len_d   = len_w;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (rvalid) begin
                    // Beats past the local count, or rlast on the wrong beat, poison the entry;
                    // we still wait for rlast so the burst is fully drained before ERR.
                    beat_err = rresp[RRESP_ERR_BIT] || (burst_q == '0) ||
                               (rlast != (burst_q == 9'd1));
                    if (burst_q != '0) begin
                        burst_d = burst_q - 9'd1;
                        beats_d = beats_q - BW'(1);
                    end
                    err_d = err_q || beat_err;
                    if (rlast) begin
                        if (err_d) begin
                            state_d = ST_ERR;
                        end else if (beats_d == '0) begin
                            state_d = ST_POP;
                        end else begin
                            if (op_q == OP_INCR) addr_d = addr_q + (32'(len_q) << size_q);
                            state_d = ST_ADDR;
                        end
                    end
                end
            end
            ST_POP, ST_ERR: begin
                sel_d   = ~sel_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sel_q   <= 1'b0;
            addr_q  <= '0;
            beats_q <= '0;
            burst_q <= '0;
            len_q   <= '0;
            size_q  <= '0;
            op_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            beats_q <= beats_d;
            burst_q <= burst_d;
            len_q   <= len_d;
            size_q  <= size_d;
            op_q    <= op_d;
            err_q   <= err_d;
        end
    end

    assign rdCache1Sel = sel_q;

    always_comb begin
        arvalid        = 1'b0;
        araddr         = '0;
        arlen          = '0;
        arsize         = '0;
        arburst        = '0;
        rready         = 1'b0;
        clrRdTranQueue = '0;
        tranDone       = 1'b0;
        tranErr        = 1'b0;
        case (state_q)
            ST_ADDR: begin
                arvalid = 1'b1;
                araddr  = addr_q;
                arlen   = 8'(len_w - 9'd1);
                arsize  = size_q;
                arburst = (op_q == OP_FIXED) ? BURST_FIXED : BURST_INCR;
            end
            ST_DATA: rready = 1'b1;
            ST_POP: begin
                clrRdTranQueue[sel_q] = 1'b1;
                tranDone              = 1'b1;
            end
            ST_ERR: begin
                clrRdTranQueue[sel_q] = 1'b1;
                tranErr               = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rd_tran_sequencer.sv
// Self-checking bench for rd_tran_sequencer: a transaction-level model predicts the AR bursts
// and the pop outcome of each entry; a checker process compares the DUT every cycle.
module tb_rd_tran_sequencer;

    localparam int unsigned TSW = 23;
    localparam int unsigned MBL = 16;

    logic           clock = 1'b0;
    logic           reset;
    logic           reqInQueue, dataValid, spaceWrTranQueue;
    logic [31:0]    srcAddr;
    logic [1:0]     srcOp;
    logic [2:0]     srcDataWidth;
    logic [TSW-1:0] numOfBytes;
    logic           rdCache1Sel;
    logic [1:0]     clrRdTranQueue;
    logic           arvalid, arready;
    logic [31:0]    araddr;
    logic [7:0]     arlen;
    logic [2:0]     arsize;
    logic [1:0]     arburst;
    logic           rvalid, rlast, rready;
    logic [1:0]     rresp;
    logic           tranDone, tranErr;

    rd_tran_sequencer #(
        .MAX_TRAN_SIZE_WIDTH (TSW),
        .MAX_BURST_LEN       (MBL)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .reqInQueue       (reqInQueue),
        .dataValid        (dataValid),
        .srcAddr          (srcAddr),
        .srcOp            (srcOp),
        .srcDataWidth     (srcDataWidth),
        .numOfBytes       (numOfBytes),
        .spaceWrTranQueue (spaceWrTranQueue),
        .rdCache1Sel      (rdCache1Sel),
        .clrRdTranQueue   (clrRdTranQueue),
        .arvalid          (arvalid),
        .araddr           (araddr),
        .arlen            (arlen),
        .arsize           (arsize),
        .arburst          (arburst),
        .arready          (arready),
        .rvalid           (rvalid),
        .rlast            (rlast),
        .rresp            (rresp),
        .rready           (rready),
        .tranDone         (tranDone),
        .tranErr          (tranErr)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } ar_t;

    ar_t exp_ar[$];
    ar_t ar_log[$];
    int  tests = 0;
    int  fails = 0;
    int  exp_kind;   // 1 = clean finish, 2 = aborted
    bit  exp_sel;
    bit  exp_hold;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Descriptor -> list of expected AR bursts and final outcome.
    task automatic build_model(input bit dv, input logic [31:0] a, input logic [1:0] op,
                               input logic [2:0] w, input int unsigned nb, input int unsigned err_beat);
        int unsigned beats, done_b, len, bsz;
        logic [31:0] cur;
        ar_t e;
        exp_ar.delete();
        exp_kind = 1;
        if (!dv) return;
        bsz = 1 << w;
        if (w > 3 || op[1] || nb == 0 || (a % bsz) != 0) begin
            exp_kind = 2;
            return;
        end
        beats  = (nb + bsz - 1) / bsz;
        cur    = a;
        done_b = 0;
        while (done_b < beats) begin
            len = beats - done_b;
            if (len > MBL) len = MBL;
`ifdef RD_TRAN_SEQ_4K_SPLIT_EN
            if (op == 2'b00 && (4096 - cur % 4096) / bsz < len) len = (4096 - cur % 4096) / bsz;
`endif
            e.addr  = cur;
            e.len   = 8'(len - 1);
            e.size  = w;
            e.burst = (op == 2'b00) ? 2'b01 : 2'b00;
            exp_ar.push_back(e);
            done_b += len;
            if (op == 2'b00) cur += len * bsz;
            if (err_beat != 0 && done_b >= err_beat) begin
                exp_kind = 2;
                break;
            end
        end
    endtask

    // Checker: runs every cycle on the falling edge.
    initial begin
        ar_t g, e, p;
        bit pv, pr;
        pv = 1'b0;
        pr = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                pv = 1'b0;
                pr = 1'b0;
                continue;
            end
            chk("rdCache1Sel", 32'(rdCache1Sel), 32'(exp_sel));
            if (exp_hold) begin
                chk("hold_arvalid", 32'(arvalid), 32'd0);
                chk("hold_clr", 32'(clrRdTranQueue), 32'd0);
            end
            if (arvalid && pv && !pr) begin
                chk("stable_araddr", araddr, p.addr);
                chk("stable_arlen", 32'(arlen), 32'(p.len));
                chk("stable_arsize", 32'(arsize), 32'(p.size));
                chk("stable_arburst", 32'(arburst), 32'(p.burst));
            end
            if (arvalid && arready) begin
                g = '{araddr, arlen, arsize, arburst};
                ar_log.push_back(g);
                if (exp_ar.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_ar: got araddr 0x%0h, required no AR", araddr);
                end else begin
                    e = exp_ar.pop_front();
                    chk("araddr", araddr, e.addr);
                    chk("arlen", 32'(arlen), 32'(e.len));
                    chk("arsize", 32'(arsize), 32'(e.size));
                    chk("arburst", 32'(arburst), 32'(e.burst));
                end
            end
            if (clrRdTranQueue != 2'b00 || tranDone || tranErr) begin
                chk("pop_clr", 32'(clrRdTranQueue), exp_sel ? 32'd2 : 32'd1);
                chk("tranDone", 32'(tranDone), 32'(exp_kind == 1));
                chk("tranErr", 32'(tranErr), 32'(exp_kind == 2));
                chk("pending_ar", 32'(exp_ar.size()), 32'd0);
                exp_sel = !exp_sel;
            end
            pv = arvalid;
            pr = arready;
            p  = '{araddr, arlen, arsize, arburst};
        end
    end

    // Presents one queue entry and plays the AXI slave until the entry is popped.
    task automatic run_entry(input bit dv, input logic [31:0] a, input logic [1:0] op,
                             input logic [2:0] w, input int unsigned nb, input int unsigned err_beat,
                             input int unsigned ar_stall, input int unsigned hold,
                             output int pop_cyc, output int first_ar);
        int unsigned rem, beat, stall;
        bit hs_ar, hs_r, popped, done;
        logic [7:0] len_s;
        build_model(dv, a, op, w, nb, err_beat);
        ar_log.delete();
        rem = 0; beat = 0; stall = 0; done = 1'b0;
        pop_cyc = -1; first_ar = -1;
        dataValid        = dv;
        srcAddr          = a;
        srcOp            = op;
        srcDataWidth     = w;
        numOfBytes       = TSW'(nb);
        spaceWrTranQueue = (hold == 0);
        exp_hold         = (hold != 0);
        reqInQueue       = 1'b1;
        for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
            @(negedge clock);
            hs_ar  = arvalid && arready;
            hs_r   = rvalid && rready;
            len_s  = arlen;
            popped = (clrRdTranQueue != 2'b00);
            if (arvalid && first_ar < 0) first_ar = cyc;
            @(posedge clock);
            #1;
            if (hs_ar) begin
                rem   = 32'(len_s) + 32'd1;
                stall = 0;
            end
            if (hs_r && rem > 0) begin
                rem--;
                beat++;
            end
            if (popped) begin
                pop_cyc    = cyc;
                done       = 1'b1;
                reqInQueue = 1'b0;
            end
            if (cyc + 1 == int'(hold)) begin
                spaceWrTranQueue = 1'b1;
                exp_hold         = 1'b0;
            end
            arready = arvalid && (stall >= ar_stall);
            if (arvalid && !arready) stall++;
            rvalid = (rem > 0);
            rlast  = (rem == 1);
            rresp  = (rem > 0 && beat + 1 == err_beat) ? 2'b10 : 2'b00;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL timeout: got no pop within cycle budget, required one pop");
            reqInQueue = 1'b0;
            exp_hold   = 1'b0;
        end
    endtask

    initial begin
        int pc, fa;
        reset = 1'b1;
        reqInQueue = 1'b0; dataValid = 1'b0; spaceWrTranQueue = 1'b0;
        srcAddr = '0; srcOp = '0; srcDataWidth = '0; numOfBytes = '0;
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = '0;
        exp_sel = 1'b0; exp_hold = 1'b0; exp_kind = 0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_arvalid", 32'(arvalid), 32'd0);
        chk("rst_rready", 32'(rready), 32'd0);
        chk("rst_clr", 32'(clrRdTranQueue), 32'd0);
        chk("rst_sel", 32'(rdCache1Sel), 32'd0);
        chk("rst_done_err", 32'({tranDone, tranErr}), 32'd0);
        chk("rst_araddr", araddr, 32'd0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Pass-through entries: pop in the second cycle, slot 0 then slot 1.
        run_entry(1'b0, 32'h0, 2'b00, 3'd0, 4, 0, 0, 0, pc, fa);
        chk("pt_pop_cycle", 32'(pc), 32'd1);
        chk("pt_no_ar", 32'(ar_log.size()), 32'd0);
        run_entry(1'b0, 32'h0, 2'b00, 3'd0, 4, 0, 0, 0, pc, fa);
        chk("pt2_sel_after", 32'(rdCache1Sel), 32'd0);

        // Aligned INCR: 256 bytes of 8-byte beats -> two 16-beat bursts.
        run_entry(1'b1, 32'h1000, 2'b00, 3'd3, 256, 0, 0, 0, pc, fa);
        chk("inc_nbursts", 32'(ar_log.size()), 32'd2);
        if (ar_log.size() == 2) begin
            chk("inc_addr0", ar_log[0].addr, 32'h1000);
            chk("inc_addr1", ar_log[1].addr, 32'h1080);
            chk("inc_len1", 32'(ar_log[1].len), 32'd15);
        end
        chk("inc_sel_after", 32'(rdCache1Sel), 32'd1);

        // 4KB boundary descriptor.
        run_entry(1'b1, 32'h0FF0, 2'b00, 3'd2, 32, 0, 1, 0, pc, fa);
`ifdef RD_TRAN_SEQ_4K_SPLIT_EN
        chk("k4_nbursts", 32'(ar_log.size()), 32'd2);
        if (ar_log.size() == 2) begin
            chk("k4_len0", 32'(ar_log[0].len), 32'd3);
            chk("k4_addr1", ar_log[1].addr, 32'h1000);
        end
`else
        chk("k4_nbursts", 32'(ar_log.size()), 32'd1);
        if (ar_log.size() == 1) chk("k4_len0", 32'(ar_log[0].len), 32'd7);
`endif

        // Error response on beat 3: drain, abort, no second burst.
        run_entry(1'b1, 32'h2000, 2'b00, 3'd3, 256, 3, 0, 0, pc, fa);
        chk("err_nbursts", 32'(ar_log.size()), 32'd1);

        // Back-pressure from the write queue plus AR stalls.
        run_entry(1'b1, 32'h3000, 2'b00, 3'd2, 64, 0, 3, 3, pc, fa);
        chk("bp_first_ar", 32'(fa), 32'd4);
        chk("bp_nbursts", 32'(ar_log.size()), 32'd1);

        // FIXED burst: 20 beats of 2 bytes, address never advances.
        run_entry(1'b1, 32'h4000, 2'b01, 3'd1, 40, 0, 0, 0, pc, fa);
        chk("fix_nbursts", 32'(ar_log.size()), 32'd2);
        if (ar_log.size() == 2) begin
            chk("fix_addr1", ar_log[1].addr, 32'h4000);
            chk("fix_len1", 32'(ar_log[1].len), 32'd3);
        end

        // 10 bytes of 4-byte beats round up to 3 beats.
        run_entry(1'b1, 32'h5000, 2'b00, 3'd2, 10, 0, 0, 0, pc, fa);
        chk("rnd_nbursts", 32'(ar_log.size()), 32'd1);
        if (ar_log.size() == 1) chk("rnd_len", 32'(ar_log[0].len), 32'd2);

        // Illegal descriptors abort without any AR.
        run_entry(1'b1, 32'h6000, 2'b00, 3'd4, 64, 0, 0, 0, pc, fa);
        chk("bad_width_ar", 32'(ar_log.size()), 32'd0);
        run_entry(1'b1, 32'h6002, 2'b00, 3'd2, 64, 0, 0, 0, pc, fa);
        chk("bad_align_ar", 32'(ar_log.size()), 32'd0);
        run_entry(1'b1, 32'h6000, 2'b10, 3'd2, 64, 0, 0, 0, pc, fa);
        chk("bad_op_ar", 32'(ar_log.size()), 32'd0);
        run_entry(1'b1, 32'h6000, 2'b00, 3'd2, 0, 0, 0, 0, pc, fa);
        chk("bad_zero_ar", 32'(ar_log.size()), 32'd0);

        // Reset in the middle of a data phase.
        build_model(1'b1, 32'h7000, 2'b00, 3'd3, 256, 0);
        dataValid = 1'b1; srcAddr = 32'h7000; srcOp = 2'b00; srcDataWidth = 3'd3;
        numOfBytes = TSW'(256); spaceWrTranQueue = 1'b1; reqInQueue = 1'b1; arready = 1'b1;
        for (int i = 0; i < 50 && !rready; i++) begin
            @(posedge clock);
            #1;
        end
        chk("mid_reached_data", 32'(rready), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_arvalid", 32'(arvalid), 32'd0);
        chk("mid_rready", 32'(rready), 32'd0);
        chk("mid_sel", 32'(rdCache1Sel), 32'd0);
        chk("mid_clr_done_err", 32'({clrRdTranQueue, tranDone, tranErr}), 32'd0);
        exp_ar.delete();
        exp_sel = 1'b0;
        reqInQueue = 1'b0; arready = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        run_entry(1'b0, 32'h0, 2'b00, 3'd0, 4, 0, 0, 0, pc, fa);
        chk("post_rst_pop_cycle", 32'(pc), 32'd1);

        repeat (2) @(posedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1);
    end

endmodule
